// File: rtl/modport_bridge_pkg.sv
// Shared types and defaults for the AHB-Lite to APB bridge.
// Holds the FSM state enum, bus codes and the address window defaults.
package ahb_apb_pkg;

    localparam int          NUM_SLAVES_DEF = 4;
    localparam logic [31:0] SLV_BASE_DEF   = 32'h8000_0000;
    localparam logic [31:0] SLV_SPAN_DEF   = 32'h0400_0000;

    localparam logic [1:0] TRN_IDLE   = 2'b00;
    localparam logic [1:0] TRN_BUSY   = 2'b01;
    localparam logic [1:0] TRN_NONSEQ = 2'b10;
    localparam logic [1:0] TRN_SEQ    = 2'b11;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    localparam logic [2:0] SIZE_WORD  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        WWAIT,
        SETUP,
        ENABLE
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
    } req_t;

endpackage

// File: rtl/modport_bridge_if.sv
// AHB-Lite slave side plus APB master side of the bridge as one bundle.
// slave: the bridge's view; master: the fabric/peripheral view.
interface modport_bridge_if #(
    parameter int NUM_SLAVES = 4
);
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic                  HSELAPBif;
    logic                  HREADYin;
    logic [31:0]           HADDR;
    logic [2:0]            HSIZE;
    logic [31:0]           HWDATA;
    logic                  HREADYout;
    logic [1:0]            HRESP;
    logic [31:0]           HRDATA;
    logic [NUM_SLAVES-1:0] PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PADDR;
    logic [31:0]           PWDATA;
    logic [31:0]           PRDATA;

    modport slave (
        input  HTRANS, HWRITE, HSELAPBif, HREADYin,
        input  HADDR, HSIZE, HWDATA, PRDATA,
        output HREADYout, HRESP, HRDATA,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport master (
        output HTRANS, HWRITE, HSELAPBif, HREADYin,
        output HADDR, HSIZE, HWDATA, PRDATA,
        input  HREADYout, HRESP, HRDATA,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/modport_bridge_apb_addr_decoder.sv
// Combinational HADDR decode: window hit flag and one-hot slave select.
module apb_addr_decoder
    import ahb_apb_pkg::*;
#(
    parameter int          NUM_SLAVES = NUM_SLAVES_DEF,
    parameter logic [31:0] SLV_BASE   = SLV_BASE_DEF,
    parameter logic [31:0] SLV_SPAN   = SLV_SPAN_DEF
) (
    input  logic [31:0]           addr,
    output logic                  hit,
    output logic [NUM_SLAVES-1:0] sel
);

    logic [63:0] off;
    logic [63:0] lo;

    // 64-bit offset: addresses below the base wrap huge and never match
    always_comb begin
        off = {32'h0, addr} - {32'h0, SLV_BASE};
        lo  = '0;
        sel = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            lo = 64'(k) * {32'h0, SLV_SPAN};
            if (off >= lo && off < lo + {32'h0, SLV_SPAN})
                sel[k] = 1'b1;
        end
        hit = |sel;
    end

endmodule

// File: rtl/modport_bridge.sv
// AHB-Lite slave to APB2 bridge: one SETUP/ENABLE pair per valid AHB beat,
// wait states through HREADYout, one-hot PSEL from the address window.
module modport_bridge
    import ahb_apb_pkg::*;
#(
    parameter int          NUM_SLAVES = NUM_SLAVES_DEF,
    parameter logic [31:0] SLV_BASE   = SLV_BASE_DEF,
    parameter logic [31:0] SLV_SPAN   = SLV_SPAN_DEF
) (
    input logic              HCLK,
    input logic              HRESET,
    modport_bridge_if.slave  bus
);

    state_t                state;
    state_t                state_nxt;
    logic                  hit;
    logic [NUM_SLAVES-1:0] sel;
    logic                  valid;
    logic                  accept;
    req_t                  req_q;
    logic [NUM_SLAVES-1:0] sel_q;
    logic [NUM_SLAVES-1:0] psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [31:0]           paddr_q;
    logic [31:0]           pwdata_q;
    logic [31:0]           hrdata_q;
    logic                  ready;
    logic                  rd_enable;
    logic                  unused_ok;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_BASE   (SLV_BASE),
        .SLV_SPAN   (SLV_SPAN)
    ) u_dec (
        .addr (bus.HADDR),
        .hit  (hit),
        .sel  (sel)
    );

    assign valid = bus.HSELAPBif & bus.HREADYin
                 & bus.HTRANS[1] & hit;
    assign ready = (state == IDLE) || (state == ENABLE);
    assign accept = valid & ready;
    assign rd_enable = (state == ENABLE) && !pwrite_q;

    // HTRANS[0] only separates IDLE/BUSY and NONSEQ/SEQ; size is kept for debug
    assign unused_ok = ^{req_q.size, bus.HTRANS[0]};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, ENABLE: begin
                if (valid)
                    state_nxt = bus.HWRITE ? WWAIT : SETUP;
                else
                    state_nxt = IDLE;
            end
            WWAIT:   state_nxt = SETUP;
            SETUP:   state_nxt = ENABLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= IDLE;
            req_q     <= '0;
            sel_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            hrdata_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q <= '{addr: bus.HADDR,
                           write: bus.HWRITE,
                           size: bus.HSIZE};
                sel_q <= sel;
            end
            if (state == WWAIT)
                pwdata_q <= bus.HWDATA;
            if (rd_enable)
                hrdata_q <= bus.PRDATA;
            // APB outputs follow the state being entered
            unique case (state_nxt)
                SETUP: begin
                    penable_q <= 1'b0;
                    if (state == WWAIT) begin
                        psel_q   <= sel_q;
                        paddr_q  <= req_q.addr;
                        pwrite_q <= req_q.write;
                    end else begin
                        psel_q   <= sel;
                        paddr_q  <= bus.HADDR;
                        pwrite_q <= bus.HWRITE;
                    end
                end
                ENABLE: penable_q <= 1'b1;
                default: begin
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.HREADYout = ready;
    assign bus.HRESP     = RESP_OKAY;
    assign bus.HRDATA    = rd_enable ? bus.PRDATA : hrdata_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_modport_bridge.sv
// Directed bench for modport_bridge: single write/read, burst, misses,
// write-then-read and asynchronous reset in the middle of an access.
module tb_modport_bridge;
    import ahb_apb_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    modport_bridge_if #(.NUM_SLAVES(4)) bus ();

    modport_bridge dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] trn,
                       input logic wr,
                       input logic [31:0] addr);
        bus.HTRANS = trn;
        bus.HWRITE = wr;
        bus.HADDR  = addr;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic [31:0] bdata [4];

    initial begin
        total = 0;
        bad   = 0;
        bdata[0] = 32'h1111_0000;
        bdata[1] = 32'h2222_0004;
        bdata[2] = 32'h3333_0008;
        bdata[3] = 32'h4444_000C;
        rst = 1'b1;
        bus.HSELAPBif = 1'b1;
        bus.HREADYin  = 1'b1;
        bus.HSIZE     = SIZE_WORD;
        bus.HWDATA    = '0;
        bus.PRDATA    = '0;
        drv(TRN_IDLE, 1'b0, 32'h0);
        smp();
        chk("rst_psel", 32'(bus.PSEL), 32'h0);
        chk("rst_ready", 32'(bus.HREADYout), 32'h1);
        chk("rst_hrdata", bus.HRDATA, 32'h0);
        chk("rst_paddr", bus.PADDR, 32'h0);
        cyc();
        cyc();
        rst = 1'b0;

        // single write
        drv(TRN_NONSEQ, 1'b1, 32'h8000_0010);
        smp();
        chk("w_addr_ready", 32'(bus.HREADYout), 32'h1);
        cyc();
        drv(TRN_IDLE, 1'b0, 32'h0);
        bus.HWDATA = 32'hDEAD_BEEF;
        smp();
        chk("w_wwait_ready", 32'(bus.HREADYout), 32'h0);
        chk("w_wwait_psel", 32'(bus.PSEL), 32'h0);
        cyc();
        smp();
        chk("w_setup_ready", 32'(bus.HREADYout), 32'h0);
        chk("w_setup_psel", 32'(bus.PSEL), 32'h1);
        chk("w_setup_pen", 32'(bus.PENABLE), 32'h0);
        chk("w_setup_pwrite", 32'(bus.PWRITE), 32'h1);
        chk("w_setup_paddr", bus.PADDR, 32'h8000_0010);
        chk("w_setup_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
        cyc();
        smp();
        chk("w_en_pen", 32'(bus.PENABLE), 32'h1);
        chk("w_en_psel", 32'(bus.PSEL), 32'h1);
        chk("w_en_ready", 32'(bus.HREADYout), 32'h1);
        cyc();
        smp();
        chk("w_idle_psel", 32'(bus.PSEL), 32'h0);
        chk("w_idle_pen", 32'(bus.PENABLE), 32'h0);
        chk("w_idle_paddr", bus.PADDR, 32'h8000_0010);

        // single read
        drv(TRN_NONSEQ, 1'b0, 32'h8800_0004);
        bus.PRDATA = 32'h1234_5678;
        cyc();
        drv(TRN_IDLE, 1'b0, 32'h0);
        smp();
        chk("r_setup_ready", 32'(bus.HREADYout), 32'h0);
        chk("r_setup_psel", 32'(bus.PSEL), 32'h4);
        chk("r_setup_pwrite", 32'(bus.PWRITE), 32'h0);
        chk("r_setup_paddr", bus.PADDR, 32'h8800_0004);
        cyc();
        smp();
        chk("r_en_ready", 32'(bus.HREADYout), 32'h1);
        chk("r_en_pen", 32'(bus.PENABLE), 32'h1);
        chk("r_en_hrdata", bus.HRDATA, 32'h1234_5678);
        cyc();
        bus.PRDATA = 32'h0;
        smp();
        chk("r_hold_hrdata", bus.HRDATA, 32'h1234_5678);
        chk("r_idle_psel", 32'(bus.PSEL), 32'h0);

        // burst of four writes to slave 3
        drv(TRN_NONSEQ, 1'b1, 32'h8C00_0000);
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.HWDATA = bdata[i];
            if (i < 3)
                drv(TRN_SEQ, 1'b1, 32'h8C00_0000 + 32'(4 * (i + 1)));
            else
                drv(TRN_IDLE, 1'b0, 32'h0);
            smp();
            chk($sformatf("b%0d_wwait_ready", i),
                32'(bus.HREADYout), 32'h0);
            cyc();
            smp();
            chk($sformatf("b%0d_psel", i), 32'(bus.PSEL), 32'h8);
            chk($sformatf("b%0d_paddr", i), bus.PADDR,
                32'h8C00_0000 + 32'(4 * i));
            chk($sformatf("b%0d_pwdata", i), bus.PWDATA, bdata[i]);
            chk($sformatf("b%0d_setup_pen", i), 32'(bus.PENABLE), 32'h0);
            cyc();
            smp();
            chk($sformatf("b%0d_en_pen", i), 32'(bus.PENABLE), 32'h1);
            chk($sformatf("b%0d_en_ready", i), 32'(bus.HREADYout), 32'h1);
        end
        cyc();
        smp();
        chk("b_end_psel", 32'(bus.PSEL), 32'h0);

        // out-of-range address, then BUSY inside the window
        drv(TRN_NONSEQ, 1'b1, 32'h7000_0000);
        for (int i = 0; i < 2; i++) begin
            cyc();
            smp();
            chk("miss_ready", 32'(bus.HREADYout), 32'h1);
            chk("miss_psel", 32'(bus.PSEL), 32'h0);
            chk("miss_resp", 32'(bus.HRESP), 32'h0);
        end
        drv(TRN_BUSY, 1'b0, 32'h8000_0000);
        for (int i = 0; i < 2; i++) begin
            cyc();
            smp();
            chk("busy_ready", 32'(bus.HREADYout), 32'h1);
            chk("busy_psel", 32'(bus.PSEL), 32'h0);
            chk("busy_resp", 32'(bus.HRESP), 32'h0);
        end
        drv(TRN_NONSEQ, 1'b0, 32'h9000_0000);
        cyc();
        smp();
        chk("top_miss_psel", 32'(bus.PSEL), 32'h0);
        chk("top_miss_ready", 32'(bus.HREADYout), 32'h1);

        // write then read to slave 1
        drv(TRN_NONSEQ, 1'b1, 32'h8400_0000);
        cyc();
        bus.HWDATA = 32'hA5A5_5A5A;
        drv(TRN_NONSEQ, 1'b0, 32'h8400_0008);
        smp();
        chk("wr_wwait_ready", 32'(bus.HREADYout), 32'h0);
        cyc();
        smp();
        chk("wr_setup_psel", 32'(bus.PSEL), 32'h2);
        chk("wr_setup_pwrite", 32'(bus.PWRITE), 32'h1);
        chk("wr_setup_pwdata", bus.PWDATA, 32'hA5A5_5A5A);
        cyc();
        bus.PRDATA = 32'hCAFE_F00D;
        smp();
        chk("wr_en_pen", 32'(bus.PENABLE), 32'h1);
        chk("wr_en_hrdata", bus.HRDATA, 32'h1234_5678);
        cyc();
        drv(TRN_IDLE, 1'b0, 32'h0);
        smp();
        chk("wr_rsetup_pwrite", 32'(bus.PWRITE), 32'h0);
        chk("wr_rsetup_psel", 32'(bus.PSEL), 32'h2);
        chk("wr_rsetup_paddr", bus.PADDR, 32'h8400_0008);
        chk("wr_rsetup_pen", 32'(bus.PENABLE), 32'h0);
        cyc();
        smp();
        chk("wr_ren_hrdata", bus.HRDATA, 32'hCAFE_F00D);
        chk("wr_ren_ready", 32'(bus.HREADYout), 32'h1);
        cyc();

        // asynchronous reset while in ENABLE
        drv(TRN_NONSEQ, 1'b0, 32'h8000_0020);
        bus.PRDATA = 32'h0BAD_0BAD;
        cyc();
        drv(TRN_IDLE, 1'b0, 32'h0);
        cyc();
        smp();
        chk("pre_rst_pen", 32'(bus.PENABLE), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_psel", 32'(bus.PSEL), 32'h0);
        chk("mid_rst_pen", 32'(bus.PENABLE), 32'h0);
        chk("mid_rst_ready", 32'(bus.HREADYout), 32'h1);
        chk("mid_rst_hrdata", bus.HRDATA, 32'h0);
        chk("mid_rst_paddr", bus.PADDR, 32'h0);
        cyc();
        rst = 1'b0;
        cyc();
        smp();
        chk("post_rst_psel", 32'(bus.PSEL), 32'h0);
        chk("post_rst_pen", 32'(bus.PENABLE), 32'h0);
        chk("post_rst_ready", 32'(bus.HREADYout), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
